// File: rtl/vga_fill_ctrl.sv
// Avalon-MM rectangle-fill and direct-plot sequencer for the 160x120 VGA adapter plot port.
// Optional fill-complete interrupt enabled by defining VGA_FILL_IRQ_EN.
module vga_fill_ctrl #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t     state;
    logic [7:0] org_x, size_w, fx0, fw, cnt_x;
    logic [6:0] org_y, size_h, fy0, fh, cnt_y;
    logic [2:0] colour, fcol;
    logic       done, pend;
    logic       plot_wr, ctrl_wr, start_wr, size_zero, emit;
    logic [7:0] sel_x0, sel_w, cur_cx, nx;
    logic [6:0] sel_y0, sel_h, cur_cy, ny;
    logic [2:0] sel_col;
    logic [8:0] px;
    logic [7:0] py;
    logic       pin, last_col, last_row, direct_in;
    logic       irq_en_rd;
    logic       unused_bits;

    assign unused_bits = ^{writedata[31:19], writedata[7]};

    assign plot_wr   = write && (address == 4'd4);
    assign ctrl_wr   = write && (address == 4'd0);
    assign start_wr  = ctrl_wr && writedata[0] && (state == IDLE);
    assign size_zero = (size_w == 8'd0) || (size_h == 7'd0);
    assign direct_in = (writedata[15:8] < 8'(SCREEN_W)) && (writedata[6:0] < 7'(SCREEN_H));

    // In IDLE the first pixel comes straight from the programmed registers so it lands in T+1
    always_comb begin
        sel_x0   = (state == IDLE) ? org_x  : fx0;
        sel_y0   = (state == IDLE) ? org_y  : fy0;
        sel_w    = (state == IDLE) ? size_w : fw;
        sel_h    = (state == IDLE) ? size_h : fh;
        sel_col  = (state == IDLE) ? colour : fcol;
        cur_cx   = (state == IDLE) ? 8'd0   : cnt_x;
        cur_cy   = (state == IDLE) ? 7'd0   : cnt_y;
        px       = 9'(sel_x0) + 9'(cur_cx);
        py       = 8'(sel_y0) + 8'(cur_cy);
        pin      = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
        last_col = (cur_cx == sel_w - 8'd1);
        last_row = (cur_cy == sel_h - 7'd1);
        nx       = last_col ? 8'd0 : cur_cx + 8'd1;
        ny       = last_col ? cur_cy + 7'd1 : cur_cy;
        emit     = (start_wr && !size_zero) || ((state == FILL) && pend && !plot_wr);
    end

`ifdef VGA_FILL_IRQ_EN
    logic irq_en, irq_pend;
    assign irq       = irq_pend && irq_en;
    assign irq_en_rd = irq_en;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            org_x      <= '0;
            org_y      <= '0;
            size_w     <= '0;
            size_h     <= '0;
            colour     <= '0;
            fx0        <= '0;
            fy0        <= '0;
            fw         <= '0;
            fh         <= '0;
            fcol       <= '0;
            cnt_x      <= '0;
            cnt_y      <= '0;
            done       <= 1'b0;
            pend       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
`ifdef VGA_FILL_IRQ_EN
            irq_en     <= 1'b0;
            irq_pend   <= 1'b0;
`endif
        end else begin
            vga_plot <= 1'b0;

            if (write) begin
                case (address)
                    4'd1: begin org_x  <= writedata[15:8]; org_y  <= writedata[6:0]; end
                    4'd2: begin size_w <= writedata[15:8]; size_h <= writedata[6:0]; end
                    4'd3: colour <= writedata[2:0];
                    default: ;
                endcase
            end

            if (ctrl_wr && writedata[1]) begin
                done <= 1'b0;
`ifdef VGA_FILL_IRQ_EN
                irq_pend <= 1'b0;
`endif
            end
`ifdef VGA_FILL_IRQ_EN
            if (ctrl_wr) irq_en <= writedata[2];
`endif

            case (state)
                IDLE: begin
                    if (start_wr) begin
                        fx0   <= org_x;
                        fy0   <= org_y;
                        fw    <= size_w;
                        fh    <= size_h;
                        fcol  <= colour;
                        done  <= 1'b0;
`ifdef VGA_FILL_IRQ_EN
                        irq_pend <= 1'b0;
`endif
                        state <= size_zero ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (!pend) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
`ifdef VGA_FILL_IRQ_EN
                    irq_pend <= 1'b1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Fill pixel issue; a direct plot in the same cycle holds the counters instead
            if (emit) begin
                cnt_x      <= nx;
                cnt_y      <= ny;
                pend       <= !(last_col && last_row);
                vga_x      <= px[7:0];
                vga_y      <= py[6:0];
                vga_colour <= sel_col;
                vga_plot   <= pin;
            end

            if (plot_wr) begin
                vga_x      <= writedata[15:8];
                vga_y      <= writedata[6:0];
                vga_colour <= writedata[18:16];
                vga_plot   <= direct_in;
            end
        end
    end

    // Zero-wait-state register readback
    always_comb begin
        readdata = 32'd0;
        if (read) begin
            case (address)
                4'd0: readdata = {29'd0, irq_en_rd, done, (state != IDLE)};
                4'd1: readdata = {16'd0, org_x, 1'b0, org_y};
                4'd2: readdata = {16'd0, size_w, 1'b0, size_h};
                4'd3: readdata = {29'd0, colour};
                default: readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/vga_fill_ctrl.md
Name: vga_fill_ctrl

Overview:
- Avalon-MM slave controller that sequences pixel writes into the 160x120 VGA adapter's plot interface (x, y, colour, plot).
- Provides a hardware rectangle-fill engine, plus a direct single-pixel plot path from the CPU.
- Arbitrates the single plot port between the two sources.
- Sits between the softcore's Avalon bus and the vga_adapter instance, replacing direct CPU-driven plotting.

Parameters:
- SCREEN_W, 160, horizontal pixel count; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120, vertical pixel count; valid y is 0..SCREEN_H-1.

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- address  in  4  Avalon word address
- read  in  1  Avalon read strobe
- readdata  out  32  Avalon read data, combinational, zero wait states
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- vga_x  out  8  pixel x to adapter, registered
- vga_y  out  7  pixel y to adapter, registered
- vga_colour  out  3  pixel colour to adapter, registered
- vga_plot  out  1  plot strobe to adapter, registered, one cycle per pixel
- irq  out  1  fill-complete interrupt (see Optional Feature)

Behaviour:
- Reset (sync, active-high):
  - All registers zero; FSM to IDLE.
  - vga_x, vga_y, vga_colour, vga_plot, irq = 0; readdata = 0 with read low.
  - Reset asserted mid-fill aborts the fill immediately, with no further plot pulses.
- Register map (word address):
  - 0 CTRL: write bit0=1 starts a fill; write bit1=1 clears DONE. Read: bit0 BUSY, bit1 DONE.
  - 1 ORIGIN: [15:8] x0, [6:0] y0.
  - 2 SIZE: [15:8] w (0..255), [6:0] h (0..127).
  - 3 COLOUR: [2:0] fill colour.
  - 4 PLOT: write-only direct pixel; [18:16] colour, [15:8] x, [6:0] y.
  - Reads of 4..15 return 0; writes to 5..15 are ignored. Unused bits read 0.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - A CTRL start write latches ORIGIN/SIZE/COLOUR into working copies, clears DONE, sets BUSY, and moves to FILL.
  - If w==0 or h==0, go straight to DONE with no plots.
- FILL:
  - Each cycle emits one pixel in row-major order: cx = x0..x0+w-1 inner, cy = y0..y0+h-1 outer.
  - Coordinates are computed at 9/8-bit width; no wrap-around.
  - Pixels with cx>=SCREEN_W or cy>=SCREEN_H consume their cycle with vga_plot=0 (clipped).
  - After the last pixel, move to DONE.
- DONE: one cycle; sets DONE sticky, clears BUSY, returns to IDLE.
- Latency and timing:
  - Start write in cycle T gives the first pixel on the outputs in T+1.
  - An unstalled fill takes w*h cycles; BUSY reads 0 from cycle T+w*h+2.
- Start while BUSY: ignored. Writes to ORIGIN/SIZE/COLOUR while BUSY update the registers but not the running fill.
- Arbitration:
  - A direct PLOT write has priority. It drives outputs in the next cycle, with vga_plot=1 only if x<SCREEN_W and y<SCREEN_H.
  - During FILL, that cycle stalls the fill; the fill counter holds and resumes next cycle, so no pixel is lost or duplicated.
- Simultaneous start write and DONE-clear bit in the same CTRL write: start wins; DONE is 0 afterwards.
- vga_plot is low in any cycle with no pixel source.

Optional Feature:
- Macro: VGA_FILL_IRQ_EN.
- Defined:
  - irq is set in the DONE-state cycle (visible the next cycle) and stays high until a CTRL write with bit1=1 or a new start.
  - CTRL bit2 is the IRQ enable (read/write, reset 0); irq is gated by it.
- Undefined: irq tied 0; CTRL bit2 reads 0 and its writes are ignored.

Test Plan:
- Direct plot: write addr4 = 0x0005_0A14 -> next cycle vga_plot=1, x=10, y=20, colour=5, for exactly one cycle. Write x=160 -> vga_plot stays 0.
- Fill: ORIGIN=(2,3), SIZE=(3,2), COLOUR=6, start -> 6 consecutive plots in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), all colour 6. Then DONE=1, BUSY=0.
- Clipping: ORIGIN=(158,119), SIZE=(4,2), start -> 8 cycles of FILL; only (158,119) and (159,119) plotted.
- Arbitration: direct PLOT write during the 2nd pixel of a 3x1 fill -> direct pixel appears once, fill pixels remain 3 in order with a one-cycle gap, and total FILL duration is 4 cycles.
- Boundary/abort: SIZE w=0 start -> DONE without plots. Start while BUSY -> ignored. Reset asserted mid-fill -> vga_plot=0 next cycle, BUSY=0, DONE=0.
- Optional (VGA_FILL_IRQ_EN): enable bit2, 1x1 fill -> irq rises after DONE; CTRL write bit1=1 -> irq=0 next cycle.
